// File: rtl/inst_prefetch_queue_if.sv
// Fetch/decode handshake bundle for the instruction prefetch queue.
// slave is the queue's view; master is the fetch/decode environment's view.
interface inst_prefetch_queue_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_pc;
  logic [DATA_W-1:0] in_inst;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [DATA_W-1:0] out_inst;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_inst, count
  );

  modport master (
    output in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, count
  );
endinterface

// File: rtl/inst_prefetch_queue.sv
// Fall-through {pc, inst} FIFO between fetch and decode; push visible one edge later, no bypass.
// in_ready drops only when full (never depends on out_ready); flush empties the queue at the next edge.
module inst_prefetch_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  inst_prefetch_queue_if.slave  q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;
  logic             in_ready;
  logic             out_valid;
  entry_t           head;

  assign in_ready  = rst && (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = q.in_valid && in_ready;
  assign pop       = out_valid && q.out_ready;
  // Empty queue presents the all-zero nop rather than stale storage.
  assign head      = out_valid ? mem_q[rd_ptr_q] : '0;

  assign q.in_ready  = in_ready;
  assign q.out_valid = out_valid;
  assign q.out_pc    = head.pc;
  assign q.out_inst  = head.inst;
  assign q.count     = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{pc: q.in_pc, inst: q.in_inst};
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only read while count is non-zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Bench for inst_prefetch_queue: directed scenarios plus random traffic against a queue model.
module tb_inst_prefetch_queue;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic clk;
  logic rst;
  logic flush;
  int   checks;
  int   failures;

  logic [ADDR_W+DATA_W-1:0] mq [$];
  logic [DATA_W-1:0]        fill_inst [4];

  inst_prefetch_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  inst_prefetch_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .q     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [ADDR_W-1:0] exp_pc();
    return (mq.size() != 0) ? mq[0][ADDR_W+DATA_W-1:DATA_W] : '0;
  endfunction

  function automatic logic [DATA_W-1:0] exp_inst();
    return (mq.size() != 0) ? mq[0][DATA_W-1:0] : '0;
  endfunction

  function automatic logic exp_rdy();
    return rst && (mq.size() < DEPTH);
  endfunction

  // Advance one clock edge and apply the same edge to the queue model.
  task automatic cycle();
    bit push_m;
    bit pop_m;
    push_m = bus.in_valid && rst && (mq.size() < DEPTH);
    pop_m  = rst && (mq.size() != 0) && bus.out_ready;
    @(posedge clk);
    #1;
    if (!rst || flush) begin
      mq.delete();
    end else begin
      if (pop_m) void'(mq.pop_front());
      if (push_m) mq.push_back({bus.in_pc, bus.in_inst});
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b1; bus.in_pc = '0; bus.in_inst = 32'h00206413; bus.out_ready = 1'b0;
    cycle();
    cycle();
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.count !== CNT_W'(0)) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    checks++; if (bus.out_inst !== 32'h0) begin failures++; $display("FAIL reset_out_inst got=%h exp=0", bus.out_inst); end
    rst = 1'b1; bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_fill();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_pc = ADDR_W'(i * 4); bus.in_inst = fill_inst[i];
      cycle();
    end
    bus.in_valid = 1'b1; bus.in_pc = 32'd16; bus.in_inst = 32'h00248413;
    #1;
    checks++; if (bus.count !== CNT_W'(4)) begin failures++; $display("FAIL fill_count got=%0d exp=4", bus.count); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready got=%b exp=0", bus.in_ready); end
    checks++; if (bus.out_pc !== 32'd0) begin failures++; $display("FAIL fill_out_pc got=%0d exp=0", bus.out_pc); end
    checks++; if (bus.out_inst !== 32'h0) begin failures++; $display("FAIL fill_out_inst got=%h exp=0", bus.out_inst); end
    cycle();
    bus.in_valid = 1'b0;
    checks++; if (bus.count !== CNT_W'(4)) begin failures++; $display("FAIL fill_fifth_count got=%0d exp=4", bus.count); end
    checks++; if (bus.out_pc !== 32'd0) begin failures++; $display("FAIL fill_fifth_head got=%0d exp=0", bus.out_pc); end
  endtask

  task automatic test_drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bus.out_pc !== ADDR_W'(i * 4)) begin failures++; $display("FAIL drain_pc[%0d] got=%0d exp=%0d", i, bus.out_pc, i * 4); end
      checks++; if (bus.out_inst !== fill_inst[i]) begin failures++; $display("FAIL drain_inst[%0d] got=%h exp=%h", i, bus.out_inst, fill_inst[i]); end
      cycle();
    end
    bus.out_ready = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL drain_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_inst !== 32'h0) begin failures++; $display("FAIL drain_out_inst got=%h exp=0", bus.out_inst); end
    checks++; if (bus.count !== CNT_W'(0)) begin failures++; $display("FAIL drain_count got=%0d exp=0", bus.count); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL drain_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] head_pc;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_pc = $urandom; bus.in_inst = $urandom;
      cycle();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    cycle();
    checks++; if (bus.count !== CNT_W'(2)) begin failures++; $display("FAIL wrap_setup_count got=%0d exp=2", bus.count); end
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.in_pc = $urandom; bus.in_inst = $urandom;
      #1;
      checks++; if (bus.out_pc !== exp_pc()) begin failures++; $display("FAIL wrap_pop_pc[%0d] got=%h exp=%h", i, bus.out_pc, exp_pc()); end
      checks++; if (bus.out_inst !== exp_inst()) begin failures++; $display("FAIL wrap_pop_inst[%0d] got=%h exp=%h", i, bus.out_inst, exp_inst()); end
      cycle();
      checks++; if (bus.count !== CNT_W'(2)) begin failures++; $display("FAIL wrap_count[%0d] got=%0d exp=2", i, bus.count); end
    end
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1; bus.in_pc = $urandom; bus.in_inst = $urandom;
      cycle();
    end
    checks++; if (bus.count !== CNT_W'(4)) begin failures++; $display("FAIL wrap_full_count got=%0d exp=4", bus.count); end
    bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.in_pc = $urandom; bus.in_inst = $urandom;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL wrap_full_ready got=%b exp=0", bus.in_ready); end
    cycle();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    head_pc = exp_pc();
    checks++; if (bus.count !== CNT_W'(3)) begin failures++; $display("FAIL wrap_pop_only_count got=%0d exp=3", bus.count); end
    checks++; if (bus.out_pc !== head_pc) begin failures++; $display("FAIL wrap_pop_only_head got=%h exp=%h", bus.out_pc, head_pc); end
  endtask

  task automatic test_flush();
    bus.in_valid = 1'b1; bus.out_ready = 1'b1; flush = 1'b1;
    bus.in_pc = $urandom; bus.in_inst = $urandom;
    cycle();
    flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    checks++; if (bus.count !== CNT_W'(0)) begin failures++; $display("FAIL flush_count got=%0d exp=0", bus.count); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b exp=0", bus.out_valid); end
    bus.in_valid = 1'b1; bus.in_pc = 32'd20; bus.in_inst = 32'h00548413;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_bypass got=%b exp=0", bus.out_valid); end
    cycle();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL flush_repush_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_pc !== 32'd20) begin failures++; $display("FAIL flush_repush_pc got=%0d exp=20", bus.out_pc); end
    checks++; if (bus.out_inst !== 32'h00548413) begin failures++; $display("FAIL flush_repush_inst got=%h exp=00548413", bus.out_inst); end
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_reappear got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1; bus.in_pc = $urandom; bus.in_inst = $urandom;
      cycle();
    end
    checks++; if (bus.count !== CNT_W'(2)) begin failures++; $display("FAIL rstmid_setup_count got=%0d exp=2", bus.count); end
    rst = 1'b0; bus.in_valid = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=0", bus.in_ready); end
    cycle();
    rst = 1'b1; bus.in_valid = 1'b0;
    checks++; if (bus.count !== CNT_W'(0)) begin failures++; $display("FAIL rstmid_count got=%0d exp=0", bus.count); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      flush         = ($urandom_range(0, 19) == 0);
      rst           = ($urandom_range(0, 49) != 0);
      bus.in_pc     = $urandom;
      bus.in_inst   = $urandom;
      #1;
      checks++; if (bus.in_ready !== exp_rdy()) begin failures++; $display("FAIL rand_in_ready[%0d] got=%b exp=%b", n, bus.in_ready, exp_rdy()); end
      checks++; if (bus.out_valid !== (mq.size() != 0)) begin failures++; $display("FAIL rand_out_valid[%0d] got=%b exp=%b", n, bus.out_valid, mq.size() != 0); end
      checks++; if (bus.out_pc !== exp_pc()) begin failures++; $display("FAIL rand_out_pc[%0d] got=%h exp=%h", n, bus.out_pc, exp_pc()); end
      checks++; if (bus.out_inst !== exp_inst()) begin failures++; $display("FAIL rand_out_inst[%0d] got=%h exp=%h", n, bus.out_inst, exp_inst()); end
      checks++; if (bus.count !== CNT_W'(mq.size())) begin failures++; $display("FAIL rand_count[%0d] got=%0d exp=%0d", n, bus.count, mq.size()); end
      cycle();
    end
    rst = 1'b1; flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    fill_inst[0] = 32'h00000000;
    fill_inst[1] = 32'h00206413;
    fill_inst[2] = 32'h00306493;
    fill_inst[3] = 32'h0280006f;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
